// File: rtl/zone_lin_buffer.sv
// ---------------------------------------------------------------------------
// zone_lin_buffer
//
// Per-line dark-pixel vote split into NZONE horizontal zones. During a scan
// line the block counts dark active pixels in each zone. On the next hsync
// rising edge it commits one dark/bright decision bit per zone.
//
// Ports
//   clk_i     in   1      pixel clock
//   rst_i     in   1      synchronous reset, active-high
//   freeze_i  in   1      1: hold rx_o at line edges (counters still restart)
//   hs_i      in   1      hsync, line boundary on its rising edge
//   de_i      in   1      data enable, pixel valid
//   wd_i      in   WIDTH  pixel luminance
//   rx_o      out  NZONE  committed per-zone decision, 1 = zone dark
//   stb_o     out  1      one-cycle pulse after every commit (also when frozen)
//
// Configuration macro
//   ZONE_LIN_BUFFER_HYST_EN : when defined, each zone uses hysteresis. A zone
//   that is currently dark stays dark while its count is >= LO. A zone that
//   is currently bright turns dark when its count is >= HI. When the macro
//   is undefined, a single threshold HI is used.
// ---------------------------------------------------------------------------
module zone_lin_buffer #(
  parameter int WIDTH    = 8,
  parameter int NZONE    = 4,
  parameter int ZONE_W   = 480,
  parameter int DARK_LVL = 64,
  parameter int HI_PCT   = 50,
  parameter int LO_PCT   = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             freeze_i,
  input  logic             hs_i,
  input  logic             de_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [NZONE-1:0] rx_o,
  output logic             stb_o
);

  localparam int TOTAL = NZONE * ZONE_W;
  localparam int XW    = $clog2(TOTAL) + 1;
  localparam int CW    = $clog2(ZONE_W + 1);
  localparam int SW    = $clog2(ZONE_W);
  localparam int ZW    = (NZONE > 1) ? $clog2(NZONE) : 1;
  localparam int HI    = ZONE_W * HI_PCT / 100;
  localparam int LO    = ZONE_W * LO_PCT / 100;

  localparam logic [XW-1:0]  X_MAX    = XW'(TOTAL);
  localparam logic [SW-1:0]  SUB_LAST = SW'(ZONE_W - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(ZONE_W);
  localparam logic [CW-1:0]  HI_C     = CW'(HI);
  localparam logic [WIDTH:0] DARK_C   = (WIDTH + 1)'(DARK_LVL);
`ifdef ZONE_LIN_BUFFER_HYST_EN
  localparam logic [CW-1:0]  LO_C     = CW'(LO);
`endif

  // Reject parameter sets that cannot describe a valid vote.
  if ((NZONE < 1) || (ZONE_W < 2) || (LO > HI)) begin : g_cfg_err
    $error("zone_lin_buffer: invalid parameters (NZONE>=1, ZONE_W>=2, LO<=HI)");
  end

  logic             hs_r;
  logic [XW-1:0]    x_r;
  logic [SW-1:0]    sub_x_r;   // position inside the current zone
  logic [ZW-1:0]    zone_r;    // current zone index, valid while x_r < X_MAX
  logic [CW-1:0]    cnt_r [NZONE];
  logic [NZONE-1:0] rx_r;
  logic             stb_r;

  logic             edge_s;
  logic             dark_s;
  logic             in_range_s;
  logic [NZONE-1:0] dec_s;

  // Line-edge detection, pixel classification and per-zone decision.
  always_comb begin
    edge_s     = hs_i & ~hs_r;
    // The comparison is widened by one bit so that DARK_LVL = 2**WIDTH still works.
    dark_s     = ({1'b0, wd_i} < DARK_C);
    in_range_s = (x_r < X_MAX);
    dec_s      = {NZONE{1'b0}};
    for (int z = 0; z < NZONE; z++) begin
`ifdef ZONE_LIN_BUFFER_HYST_EN
      if (rx_r[z]) begin
        dec_s[z] = (cnt_r[z] >= LO_C);
      end else begin
        dec_s[z] = (cnt_r[z] >= HI_C);
      end
`else
      dec_s[z] = (cnt_r[z] >= HI_C);
`endif
    end
  end

  // Pixel/zone counters, hsync history and the registered commit outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // hs_r starts high so that hs_i held high through reset is not seen as an edge.
      hs_r    <= 1'b1;
      x_r     <= {XW{1'b0}};
      sub_x_r <= {SW{1'b0}};
      zone_r  <= {ZW{1'b0}};
      rx_r    <= {NZONE{1'b0}};
      stb_r   <= 1'b0;
      for (int z = 0; z < NZONE; z++) begin
        cnt_r[z] <= {CW{1'b0}};
      end
    end else begin
      hs_r  <= hs_i;
      stb_r <= edge_s;
      if (edge_s) begin
        // The decision uses the counts before this cycle. A de pixel in the
        // edge cycle is the first pixel (x=0) of the new line.
        if (!freeze_i) begin
          rx_r <= dec_s;
        end else begin
          rx_r <= rx_r;
        end
        x_r     <= de_i ? XW'(1) : {XW{1'b0}};
        sub_x_r <= de_i ? SW'(1) : {SW{1'b0}};
        zone_r  <= {ZW{1'b0}};
        for (int z = 0; z < NZONE; z++) begin
          cnt_r[z] <= ((z == 0) && de_i && dark_s) ? CW'(1) : {CW{1'b0}};
        end
      end else if (de_i && in_range_s) begin
        // x_r stops at X_MAX. Pixels after that point no longer advance it.
        x_r <= x_r + XW'(1);
        if (sub_x_r == SUB_LAST) begin
          sub_x_r <= {SW{1'b0}};
          zone_r  <= zone_r + ZW'(1);
        end else begin
          sub_x_r <= sub_x_r + SW'(1);
        end
        for (int z = 0; z < NZONE; z++) begin
          if ((zone_r == ZW'(z)) && dark_s && (cnt_r[z] != CNT_MAX)) begin
            cnt_r[z] <= cnt_r[z] + CW'(1);
          end
        end
      end
    end
  end

  assign rx_o  = rx_r;
  assign stb_o = stb_r;

endmodule

// File: tb/tb_zone_lin_buffer.sv
// ---------------------------------------------------------------------------
// tb_zone_lin_buffer
//
// Directed testbench for zone_lin_buffer with default parameters
// (NZONE=4, ZONE_W=480, HI=240, LO=192, DARK_LVL=64). The expected values
// are computed by hand.
// ---------------------------------------------------------------------------
module tb_zone_lin_buffer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       freeze_i;
  logic       hs_i;
  logic       de_i;
  logic [7:0] wd_i;
  logic [3:0] rx_o;
  logic       stb_o;

  int total = 0;
  int bad   = 0;

  zone_lin_buffer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .freeze_i (freeze_i),
    .hs_i     (hs_i),
    .de_i     (de_i),
    .wd_i     (wd_i),
    .rx_o     (rx_o),
    .stb_o    (stb_o)
  );

  // Free-running pixel clock.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pixels(input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) begin
      hs_i     = 1'b0;
      freeze_i = 1'b0;
      de_i     = 1'b1;
      wd_i     = w;
      tick();
    end
    de_i = 1'b0;
  endtask

  // Each zone gets d[z] dark pixels followed by bright pixels up to 480.
  task automatic line_z(input int d0, input int d1, input int d2, input int d3);
    pixels(d0, 8'd0);  pixels(480 - d0, 8'd255);
    pixels(d1, 8'd0);  pixels(480 - d1, 8'd255);
    pixels(d2, 8'd0);  pixels(480 - d2, 8'd255);
    pixels(d3, 8'd0);  pixels(480 - d3, 8'd255);
  endtask

  // Raise hsync for one cycle (hs_i must already be low), then check the commit.
  task automatic hs_edge(input string tag, input logic frz, input logic de,
                         input logic [7:0] w, input logic [3:0] exp_rx);
    hs_i     = 1'b1;
    freeze_i = frz;
    de_i     = de;
    wd_i     = w;
    tick();
    check({tag, "_stb"}, 32'(stb_o), 32'd1);
    check({tag, "_rx"},  32'(rx_o),  32'(exp_rx));
    hs_i     = 1'b0;
    freeze_i = 1'b0;
    de_i     = 1'b0;
    wd_i     = 8'd255;
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] exp_rx);
    hs_i = 1'b0;
    de_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
    check({tag, "_stb"}, 32'(stb_o), 32'd0);
    check({tag, "_rx"},  32'(rx_o),  32'(exp_rx));
  endtask

  logic [3:0] hyst_exp;

  initial begin
    rst_i = 1'b1; freeze_i = 1'b0; hs_i = 1'b1; de_i = 1'b0; wd_i = 8'd255;
`ifdef ZONE_LIN_BUFFER_HYST_EN
    hyst_exp = 4'b0010;
`else
    hyst_exp = 4'b0000;
`endif
    // 1: reset with hs high, then hold hs high for 3 cycles: no false edge.
    tick(); tick();
    check("rst_rx",  32'(rx_o),  32'd0);
    check("rst_stb", 32'(stb_o), 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stb", 32'(stb_o), 32'd0);
    end
    check("hold_rx", 32'(rx_o), 32'd0);
    idle("pre", 1, 4'h0);

    // 2: zone 0 dark, all other zones bright.
    line_z(480, 0, 0, 0);
    hs_edge("z0", 1'b0, 1'b0, 8'd255, 4'b0001);
    idle("z0_after", 1, 4'b0001);

    // 3: boundary at HI: 240 -> dark, 239 -> bright.
    line_z(0, 0, 240, 239);
    hs_edge("hi_bnd", 1'b0, 1'b0, 8'd255, 4'b0100);
    idle("stable", 5, 4'b0100);

    // 4: a frozen edge holds rx_o, then the next line commits fresh counts.
    line_z(480, 480, 480, 480);
    hs_edge("frz", 1'b1, 1'b0, 8'd255, 4'b0100);
    line_z(0, 300, 0, 0);
    hs_edge("fresh", 1'b0, 1'b0, 8'd255, 4'b0010);
    // Back-to-back edges: a full line, then a line with zero de pixels.
    line_z(480, 480, 480, 480);
    hs_edge("full", 1'b0, 1'b0, 8'd255, 4'hF);
    idle("gap", 1, 4'hF);
    hs_edge("b2b", 1'b0, 1'b0, 8'd255, 4'h0);

    // 5: overrun of 2100 dark pixels; a dark pixel in the edge cycle counts
    //    as the first pixel of the next line.
    pixels(2100, 8'd0);
    hs_edge("ovr", 1'b0, 1'b1, 8'd0, 4'hF);
    pixels(239, 8'd0); pixels(241, 8'd255); pixels(1440, 8'd255);
    hs_edge("edge_px", 1'b0, 1'b0, 8'd255, 4'b0001);
    // Dark pixels after x=1920 must be ignored (saturation, no wrap into zone 0).
    pixels(1920, 8'd255); pixels(400, 8'd0);
    hs_edge("sat", 1'b0, 1'b0, 8'd255, 4'h0);

    // Reset mid-line discards the partial line.
    line_z(480, 480, 480, 480);
    hs_edge("pre_rst", 1'b0, 1'b0, 8'd255, 4'hF);
    pixels(1000, 8'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_rx",  32'(rx_o),  32'd0);
    check("mid_rst_stb", 32'(stb_o), 32'd0);
    idle("post_rst", 1, 4'h0);
    hs_edge("rst_disc", 1'b0, 1'b0, 8'd255, 4'h0);
    // Reset asserted together with an edge: reset wins.
    pixels(1920, 8'd0);
    hs_i = 1'b1; rst_i = 1'b1;
    tick();
    check("rst_edge_stb", 32'(stb_o), 32'd0);
    rst_i = 1'b0;
    tick();
    check("rst_edge_stb2", 32'(stb_o), 32'd0);
    check("rst_edge_rx",   32'(rx_o),  32'd0);
    hs_i = 1'b0;

    // 6: hysteresis sequence on zone 1.
    line_z(0, 300, 0, 0);
    hs_edge("hy_set", 1'b0, 1'b0, 8'd255, 4'b0010);
    line_z(0, 200, 0, 0);
    hs_edge("hy_200", 1'b0, 1'b0, 8'd255, hyst_exp);
    line_z(0, 191, 0, 0);
    hs_edge("hy_191", 1'b0, 1'b0, 8'd255, 4'b0000);
    line_z(0, 200, 0, 0);
    hs_edge("hy_200b", 1'b0, 1'b0, 8'd255, 4'b0000);
    idle("end", 2, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
